// File: rtl/avalon_led_pio_blink_if.sv
// Avalon-MM slave bus bundle for the LED PIO.
//   address    3-bit word address
//   chipselect slave select
//   write_n    active-low write strobe
//   writedata  32-bit write data
//   readdata   32-bit zero-wait-state read data
interface avalon_led_pio_blink_if;
  logic [2:0]  address;
  logic        chipselect;
  logic        write_n;
  logic [31:0] writedata;
  logic [31:0] readdata;

  modport slave (
    input  address,
    input  chipselect,
    input  write_n,
    input  writedata,
    output readdata
  );

  modport master (
    output address,
    output chipselect,
    output write_n,
    output writedata,
    input  readdata
  );
endinterface

// File: rtl/avalon_led_pio_blink.sv
// Avalon-MM output PIO for board LEDs with per-channel static/blink mode,
// shared programmable blink half-period and atomic set/clear registers.
//   clk       system clock
//   reset     synchronous active-high reset
//   avs       Avalon-MM slave bus (address/chipselect/write_n/writedata/readdata)
//   out_port  registered LED outputs
module avalon_led_pio_blink #(
  parameter int unsigned       WIDTH          = 8,
  parameter int unsigned       PRESC_W        = 24,
  parameter logic [PRESC_W-1:0] DEFAULT_PERIOD = PRESC_W'(12_499_999)
) (
  input  logic                         clk,
  input  logic                         reset,
  avalon_led_pio_blink_if.slave        avs,
  output logic [WIDTH-1:0]             out_port
);

  localparam int unsigned DW = 32;

  localparam logic [2:0] A_DATA     = 3'd0;
  localparam logic [2:0] A_BLINK_EN = 3'd1;
  localparam logic [2:0] A_PERIOD   = 3'd2;
  localparam logic [2:0] A_OUTSET   = 3'd3;
  localparam logic [2:0] A_OUTCLR   = 3'd4;
  localparam logic [2:0] A_STATUS   = 3'd5;

  logic [WIDTH-1:0]   data_q, data_d;
  logic [WIDTH-1:0]   blink_en_q, blink_en_d;
  logic [PRESC_W-1:0] period_q, period_d;
  logic [PRESC_W-1:0] cnt_q, cnt_d;
  logic               phase_q, phase_d;
  logic [WIDTH-1:0]   out_q, out_d;
  logic [DW-1:0]      readdata_c;
  logic               wr_c;
  logic               unused_wdata;

  // Bits above WIDTH/PRESC_W are architecturally ignored.
  assign unused_wdata = ^avs.writedata;

  assign wr_c = avs.chipselect && !avs.write_n;

  // Register writes, blink engine and output mux.
  always_comb begin
    data_d     = data_q;
    blink_en_d = blink_en_q;
    period_d   = period_q;
    cnt_d      = cnt_q;
    phase_d    = phase_q;

    if (wr_c) begin
      case (avs.address)
        A_DATA:     data_d     = avs.writedata[WIDTH-1:0];
        A_BLINK_EN: blink_en_d = avs.writedata[WIDTH-1:0];
        A_PERIOD:   period_d   = avs.writedata[PRESC_W-1:0];
        A_OUTSET:   data_d     = data_q | avs.writedata[WIDTH-1:0];
        A_OUTCLR:   data_d     = data_q & ~avs.writedata[WIDTH-1:0];
        default:    ;
      endcase
    end

    // A PERIOD write restarts the count and beats a coincident toggle.
    if (wr_c && (avs.address == A_PERIOD)) begin
      cnt_d = '0;
    end else if (blink_en_q == '0) begin
      cnt_d   = '0;
      phase_d = 1'b1;
    end else if (cnt_q == period_q) begin
      cnt_d   = '0;
      phase_d = ~phase_q;
    end else begin
      cnt_d = cnt_q + PRESC_W'(1);
    end

    out_d = (data_q & ~blink_en_q) | (data_q & blink_en_q & {WIDTH{phase_q}});
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      data_q     <= '0;
      blink_en_q <= '0;
      period_q   <= DEFAULT_PERIOD;
      cnt_q      <= '0;
      phase_q    <= 1'b1;
      out_q      <= '0;
    end else begin
      data_q     <= data_d;
      blink_en_q <= blink_en_d;
      period_q   <= period_d;
      cnt_q      <= cnt_d;
      phase_q    <= phase_d;
      out_q      <= out_d;
    end
  end

  // Zero-wait-state read mux; no side effects, chipselect not required.
  always_comb begin
    readdata_c = '0;
    case (avs.address)
      A_DATA:     readdata_c = DW'(data_q);
      A_BLINK_EN: readdata_c = DW'(blink_en_q);
      A_PERIOD:   readdata_c = DW'(period_q);
      A_STATUS: begin
        readdata_c     = DW'(out_q);
        readdata_c[31] = phase_q;
      end
      default:    readdata_c = '0;
    endcase
  end

  assign avs.readdata = readdata_c;
  assign out_port     = out_q;

endmodule

// File: tb/tb_avalon_led_pio_blink.sv
// Directed, table-driven bench for avalon_led_pio_blink.
module tb_avalon_led_pio_blink;

  logic       clk = 1'b0;
  logic       reset;
  logic [7:0] out_port;
  int         checks = 0;
  int         errors = 0;

  avalon_led_pio_blink_if bus();

  avalon_led_pio_blink #(
    .WIDTH   (8),
    .PRESC_W (24)
  ) dut (
    .clk      (clk),
    .reset    (reset),
    .avs      (bus),
    .out_port (out_port)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic        wr;
    logic [2:0]  addr;
    logic [31:0] wdata;
    logic [31:0] exp_rd;
    logic [7:0]  exp_out;
  } vec_t;

  vec_t vecs[23];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // One write consumes exactly one clock edge.
  task automatic bus_write(input logic [2:0] a, input logic [31:0] d);
    bus.address    = a;
    bus.writedata  = d;
    bus.chipselect = 1'b1;
    bus.write_n    = 1'b0;
    tick();
    bus.chipselect = 1'b0;
    bus.write_n    = 1'b1;
  endtask

  task automatic bus_read(input logic [2:0] a, output logic [31:0] d);
    bus.address = a;
    #1;
    d = bus.readdata;
  endtask

  function automatic vec_t mk(input logic wr, input logic [2:0] a, input logic [31:0] wd,
                              input logic [31:0] rd, input logic [7:0] o);
    vec_t v;
    v.wr = wr; v.addr = a; v.wdata = wd; v.exp_rd = rd; v.exp_out = o;
    return v;
  endfunction

  initial begin
    logic [31:0] rd;
    logic [7:0]  exp_o;

    vecs[0]  = mk(1'b0, 3'd2, 32'h0, 32'h00BE_BC1F, 8'h00);
    vecs[1]  = mk(1'b0, 3'd5, 32'h0, 32'h8000_0000, 8'h00);
    vecs[2]  = mk(1'b0, 3'd0, 32'h0, 32'h0000_0000, 8'h00);
    vecs[3]  = mk(1'b1, 3'd0, 32'hA5, 32'h0, 8'h00);
    vecs[4]  = mk(1'b0, 3'd0, 32'h0, 32'h0000_00A5, 8'hA5);
    vecs[5]  = mk(1'b1, 3'd3, 32'h0F, 32'h0, 8'hA5);
    vecs[6]  = mk(1'b0, 3'd0, 32'h0, 32'h0000_00AF, 8'hAF);
    vecs[7]  = mk(1'b0, 3'd3, 32'h0, 32'h0000_0000, 8'hAF);
    vecs[8]  = mk(1'b1, 3'd4, 32'h81, 32'h0, 8'hAF);
    vecs[9]  = mk(1'b0, 3'd0, 32'h0, 32'h0000_002E, 8'h2E);
    vecs[10] = mk(1'b0, 3'd4, 32'h0, 32'h0000_0000, 8'h2E);
    vecs[11] = mk(1'b0, 3'd5, 32'h0, 32'h8000_002E, 8'h2E);
    vecs[12] = mk(1'b1, 3'd5, 32'hFFFF_FFFF, 32'h0, 8'h2E);
    vecs[13] = mk(1'b0, 3'd0, 32'h0, 32'h0000_002E, 8'h2E);
    vecs[14] = mk(1'b1, 3'd2, 32'hFFFF_FFFF, 32'h0, 8'h2E);
    vecs[15] = mk(1'b0, 3'd2, 32'h0, 32'h00FF_FFFF, 8'h2E);
    vecs[16] = mk(1'b1, 3'd6, 32'h1234_5678, 32'h0, 8'h2E);
    vecs[17] = mk(1'b0, 3'd6, 32'h0, 32'h0000_0000, 8'h2E);
    vecs[18] = mk(1'b0, 3'd7, 32'h0, 32'h0000_0000, 8'h2E);
    vecs[19] = mk(1'b1, 3'd1, 32'h1FF, 32'h0, 8'h2E);
    vecs[20] = mk(1'b0, 3'd1, 32'h0, 32'h0000_00FF, 8'h2E);
    vecs[21] = mk(1'b1, 3'd1, 32'h0, 32'h0, 8'h2E);
    vecs[22] = mk(1'b0, 3'd1, 32'h0, 32'h0000_0000, 8'h2E);

    bus.address    = 3'd0;
    bus.chipselect = 1'b0;
    bus.write_n    = 1'b1;
    bus.writedata  = 32'h0;
    reset          = 1'b1;
    repeat (3) tick();
    reset = 1'b0;
    chk("reset_out", 32'(out_port), 32'h0);

    // Register map, set/clear, ignored writes.
    for (int i = 0; i < 23; i++) begin
      if (vecs[i].wr) begin
        bus_write(vecs[i].addr, vecs[i].wdata);
      end else begin
        tick();
        bus_read(vecs[i].addr, rd);
        chk($sformatf("vec%0d_rd", i), rd, vecs[i].exp_rd);
      end
      chk($sformatf("vec%0d_out", i), 32'(out_port), 32'(vecs[i].exp_out));
    end

    // Blink PERIOD=3: bit0 4 high / 4 low starting high, bit1 static high.
    bus_write(3'd2, 32'd3);
    bus_write(3'd0, 32'h03);
    bus_write(3'd1, 32'h01);
    for (int k = 1; k <= 16; k++) begin
      tick();
      exp_o = (((k - 1) / 4) % 2 == 0) ? 8'h03 : 8'h02;
      chk($sformatf("blink_k%0d", k), 32'(out_port), 32'(exp_o));
    end

    // PERIOD rewrites restart the count and hold phase (phase is 1, cnt 0 here).
    bus_write(3'd2, 32'd7);
    bus_read(3'd5, rd);
    chk("p7_write_phase", 32'(rd[31]), 32'd1);
    for (int k = 1; k <= 5; k++) begin
      tick();
      bus_read(3'd5, rd);
      chk($sformatf("p7_cnt%0d_phase", k), 32'(rd[31]), 32'd1);
    end
    bus_write(3'd2, 32'd2);
    bus_read(3'd5, rd);
    chk("p2_write_phase", 32'(rd[31]), 32'd1);
    bus_read(3'd2, rd);
    chk("p2_readback", rd, 32'd2);
    for (int k = 1; k <= 3; k++) begin
      tick();
      bus_read(3'd5, rd);
      chk($sformatf("p2_t%0d_phase", k), 32'(rd[31]), (k == 3) ? 32'd0 : 32'd1);
    end

    // PERIOD write on the cycle a toggle would have happened: write wins.
    tick();
    tick();
    bus_write(3'd2, 32'd5);
    bus_read(3'd5, rd);
    chk("coinc_phase_held", 32'(rd[31]), 32'd0);
    for (int k = 1; k <= 6; k++) begin
      tick();
      bus_read(3'd5, rd);
      chk($sformatf("p5_t%0d_phase", k), 32'(rd[31]), (k == 6) ? 32'd1 : 32'd0);
    end

    // Reset coincident with a DATA write during blinking.
    bus.address    = 3'd0;
    bus.writedata  = 32'hFF;
    bus.chipselect = 1'b1;
    bus.write_n    = 1'b0;
    reset          = 1'b1;
    tick();
    reset          = 1'b0;
    bus.chipselect = 1'b0;
    bus.write_n    = 1'b1;
    chk("rst2_out", 32'(out_port), 32'h0);
    bus_read(3'd0, rd);
    chk("rst2_data", rd, 32'h0);
    bus_read(3'd1, rd);
    chk("rst2_blink_en", rd, 32'h0);
    bus_read(3'd2, rd);
    chk("rst2_period", rd, 32'h00BE_BC1F);
    bus_read(3'd5, rd);
    chk("rst2_status", rd, 32'h8000_0000);
    tick();
    chk("rst2_out_after", 32'(out_port), 32'h0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
